// File: rtl/group_update_sequencer.sv
// Steps the update-order LUT group index through every group, holding each slot
// for a latched number of cycles, and counts sweeps until a target or a graceful stop.
module group_update_sequencer #(
  parameter int NUM_GROUPS = 5,
  parameter int GROUP_W    = 4,
  parameter int HOLD_W     = 8,
  parameter int SWEEP_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [HOLD_W-1:0]  hold_cycles,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [0:GROUP_W-1] group_EN,
  output logic               update_valid,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [GROUP_W-1:0] LAST_GRP = GROUP_W'(NUM_GROUPS - 1);

  state_t              state;
  logic [GROUP_W-1:0]  grp;
  logic [HOLD_W-1:0]   hcnt;
  logic [HOLD_W-1:0]   hold_lat;
  logic [SWEEP_W-1:0]  sweeps_lat;
  logic                stop_lat;

  logic                slot_end;
  logic                last_grp;
  logic [SWEEP_W-1:0]  next_sc;
  logic                finish;

  assign group_EN = grp;

  always_comb begin
    slot_end = (hcnt == hold_lat - 1'b1);
    last_grp = (grp == LAST_GRP);
    next_sc  = (sweep_count == '1) ? sweep_count : sweep_count + 1'b1;
    // a stop arriving on the sweep-end edge itself still ends the run there
    finish   = ((sweeps_lat != '0) && (next_sc == sweeps_lat)) || stop_lat || stop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      grp          <= '0;
      hcnt         <= '0;
      hold_lat     <= HOLD_W'(1);
      sweeps_lat   <= '0;
      stop_lat     <= 1'b0;
      update_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sweep_count  <= '0;
    end else begin
      update_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          grp  <= '0;
          busy <= 1'b0;
          if (start) begin
            hold_lat     <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
            sweeps_lat   <= num_sweeps;
            sweep_count  <= '0;
            hcnt         <= '0;
            stop_lat     <= 1'b0;
            state        <= RUN;
            busy         <= 1'b1;
            update_valid <= 1'b1;
          end
        end
        RUN: begin
          stop_lat <= stop_lat | stop;
          if (!slot_end) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (!last_grp) begin
              grp          <= grp + 1'b1;
              update_valid <= 1'b1;
            end else begin
              sweep_count <= next_sc;
              grp         <= '0;
              if (finish) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                update_valid <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_group_update_sequencer.sv
// Scoreboard bench: each run's expected slot and done events are derived from the
// sweep/group/hold arithmetic and checked by an independent negedge monitor.
module tb_group_update_sequencer;

  localparam int NG = 5;
  localparam int GW = 4;
  localparam int HW = 8;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [HW-1:0] hold_cycles = '0;
  logic [SW-1:0] num_sweeps = '0;
  logic [0:GW-1] group_EN;
  logic          update_valid;
  logic          busy;
  logic          done;
  logic [SW-1:0] sweep_count;

  group_update_sequencer #(
    .NUM_GROUPS(NG),
    .GROUP_W(GW),
    .HOLD_W(HW),
    .SWEEP_W(SW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .hold_cycles(hold_cycles),
    .num_sweeps(num_sweeps),
    .group_EN(group_EN),
    .update_valid(update_valid),
    .busy(busy),
    .done(done),
    .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {int g; int sc; int cyc;} slot_t;
  typedef struct {int sc; int cyc;} done_t;
  slot_t slot_q[$];
  done_t done_q[$];
  bit    mon_en = 1'b1;
  int    run_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    slot_t s;
    done_t d;
    if (!mon_en || !rst_n) begin
      run_cyc = 0;
    end else begin
      if (update_valid) begin
        if (slot_q.size() == 0) begin
          chk("unexpected_update_valid", 32'd1, 32'd0);
        end else begin
          s = slot_q.pop_front();
          chk("slot_group", 32'(group_EN), s.g);
          chk("slot_sweep_count", 32'(sweep_count), s.sc);
          chk("slot_cycle", run_cyc, s.cyc);
          chk("slot_busy", 32'(busy), 32'd1);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          chk("done_sweep_count", 32'(sweep_count), d.sc);
          chk("run_length", run_cyc, d.cyc);
          chk("done_busy", 32'(busy), 32'd0);
        end
        run_cyc = 0;
      end
      if (!busy) chk("idle_group", 32'(group_EN), 32'd0);
      if (busy) run_cyc++;
    end
  end

  // stop_t / smid are RUN-cycle indices (0-based) at which stop / a stray start are driven; -1 = never
  task automatic run(input int h, input int n, input int stop_t, input int smid, input bit chain);
    int he;
    int total;
    int cyc_tot;
    he = (h == 0) ? 1 : h;
    if (stop_t >= 0) begin
      total = stop_t / (NG * he) + 1;
      if (n != 0 && n < total) total = n;
    end else begin
      total = n;
    end
    cyc_tot = total * NG * he;
    for (int sw = 0; sw < total; sw++)
      for (int g = 0; g < NG; g++)
        slot_q.push_back('{g: g, sc: sw, cyc: (sw * NG + g) * he});
    done_q.push_back('{sc: total, cyc: cyc_tot});

    start = 1'b1;
    hold_cycles = HW'(h);
    num_sweeps = SW'(n);
    tick();
    start = 1'b0;
    hold_cycles = HW'($urandom);
    num_sweeps = SW'($urandom);
    for (int c = 0; c < cyc_tot; c++) begin
      stop = (c == stop_t);
      start = (c == smid) || (chain && c >= cyc_tot - 2);
      tick();
    end
    stop = 1'b0;
    start = chain;
    if (!chain) begin
      for (int i = 0; i < 3; i++) begin
        chk("idle_sweep_hold", 32'(sweep_count), total);
        chk("idle_busy", 32'(busy), 32'd0);
        stop = 1'($urandom_range(0, 1));
        tick();
      end
      stop = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int n;
    int he;
    int st;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("reset_group", 32'(group_EN), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_uv", 32'(update_valid), 32'd0);
      chk("reset_sc", 32'(sweep_count), 32'd0);
      stop = 1'($urandom_range(0, 1));
      tick();
    end
    stop = 1'b0;

    run(3, 2, -1, -1, 1'b0);
    run(0, 1, -1, -1, 1'b0);
    // free-run, stop during group 2 of the third sweep, stray start mid-run
    run(2, 0, 2 * NG * 2 + 2 * 2, 10, 1'b0);

    mon_en = 1'b0;
    start = 1'b1;
    hold_cycles = HW'(4);
    num_sweeps = SW'(5);
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    chk("pre_reset_group", 32'(group_EN), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_group", 32'(group_EN), 32'd0);
    chk("midreset_uv", 32'(update_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_sc", 32'(sweep_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postreset_done", 32'(done), 32'd0);
      chk("postreset_busy", 32'(busy), 32'd0);
    end
    mon_en = 1'b1;
    run(4, 5, -1, -1, 1'b0);

    run(1, 2, -1, -1, 1'b1);
    run(2, 1, -1, -1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      h = $urandom_range(0, 4);
      n = $urandom_range(0, 3);
      he = (h == 0) ? 1 : h;
      if (n == 0) st = $urandom_range(0, 3 * NG * he - 1);
      else if ($urandom_range(0, 1) == 1) st = $urandom_range(0, n * NG * he - 1);
      else st = -1;
      run(h, n, st, $urandom_range(0, NG * he), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("slot_queue_drained", slot_q.size(), 32'd0);
    chk("done_queue_drained", done_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/group_update_sequencer.md
Name: group_update_sequencer

Overview:
- Upstream sequencer for the grouped p-bit update order LUT.
- Drives the group index group_EN through groups 0..NUM_GROUPS-1 in order. Holds each group for a programmable number of clock cycles so the enabled p-bits can settle.
- Counts completed sweeps and runs for a requested sweep count or free-runs. Uses a start/stop/done handshake to the controlling logic.
- Downstream logic gates Pbit_EN with busy, because index 0 is a valid group and is also the idle value.

Parameters:
- NUM_GROUPS, 5, number of update groups; legal range 2..2^GROUP_W.
- GROUP_W, 4, width of the group index output.
- HOLD_W, 8, width of the per-group hold-cycle setting.
- SWEEP_W, 16, width of the sweep target and sweep counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  request graceful termination; sampled only in RUN.
- hold_cycles  in  HOLD_W  cycles per group slot; latched at start; 0 treated as 1.
- num_sweeps  in  SWEEP_W  sweeps to run; latched at start; 0 = free-run until stop.
- group_EN  out  [0:GROUP_W-1]  current group index, fed to the update order LUT.
- update_valid  out  1  one-cycle pulse on the first cycle of every group slot.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run completes.
- sweep_count  out  SWEEP_W  completed sweeps in the current or last run.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, group_EN=0, update_valid=0, busy=0, done=0, sweep_count=0; hold counter and stop latch cleared. Reset mid-run aborts immediately with no done pulse.
- States: IDLE, RUN. Done is a registered pulse emitted on the RUN->IDLE transition.
- IDLE:
  - group_EN=0, busy=0.
  - start=1 latches hold_cycles (0->1) and num_sweeps, and clears sweep_count and the hold counter.
  - The next cycle enters RUN with group_EN=0, busy=1, update_valid=1 (1-cycle latency from start).
- RUN, slot timing:
  - The hold counter runs 0..H-1, where H is the latched hold value.
  - update_valid=1 only when the counter is 0.
  - On the cycle where counter=H-1, the slot ends.
- RUN, slot end with group_EN<NUM_GROUPS-1: group_EN increments; the counter resets to 0.
- RUN, slot end with group_EN=NUM_GROUPS-1 (sweep end):
  - sweep_count increments; it saturates at all-ones in free-run.
  - If num_sweeps≠0 and the new count equals num_sweeps, or the stop latch is set: next state is IDLE, done=1 for exactly one cycle, busy=0, group_EN=0.
  - Otherwise group_EN wraps to 0, the counter resets, and update_valid pulses.
- Stop handling:
  - A stop pulse in RUN sets the stop latch. The current sweep always completes (all groups visited), so the p-bit state is never left half-swept.
  - stop in IDLE is ignored. stop on the same cycle as a sweep-end edge terminates at that edge.
- start while busy is ignored. start on the done cycle (state already IDLE) is accepted and begins a new run the following cycle.
- H=1: group_EN advances every cycle and update_valid stays high continuously in RUN.
- Run cycle count: a full run lasts num_sweeps·NUM_GROUPS·H cycles in RUN. done asserts on the cycle after the last RUN cycle.
- sweep_count holds its final value in IDLE until the next accepted start.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 10 idle cycles -> group_EN=0, busy=0, done=0, update_valid=0, sweep_count=0 throughout.
- Basic run: hold_cycles=3, num_sweeps=2, start pulse -> group_EN sequence 0,0,0,1,1,1,…,4,4,4 repeated twice; update_valid every 3rd cycle; busy high exactly 30 cycles; done one pulse; sweep_count=2.
- Zero hold / single cycle: hold_cycles=0, num_sweeps=1 -> group_EN 0,1,2,3,4 on consecutive cycles; update_valid high all 5 cycles; done on cycle 6.
- Graceful stop: num_sweeps=0, hold_cycles=2; stop pulsed during group 2 of sweep 3 -> sweep 3 completes through group 4; done pulses; sweep_count=3; start asserted mid-run is ignored.
- Reset mid-run: hold_cycles=4, num_sweeps=5; rst_n low during group 3 of sweep 1 -> next cycle all outputs at reset values, no done pulse. A subsequent start runs a clean 5-sweep run ending with sweep_count=5.
- Back-to-back: start held high across done -> second run starts the cycle after done with sweep_count cleared to 0 and group_EN=0 with update_valid=1.
